// File: rtl/neural_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues credit-limited word requests,
// buffers returned instructions with their PCs. Optional counters: NEURAL_FETCH_PERF_EN.
module neural_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RES,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted
`ifdef NEURAL_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam int unsigned PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_C = CW1'(BUF_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALTED} state_t;

  state_t        state, state_d;
  logic [31:0]   pc_reg;
  logic [31:0]   buf_data [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [31:0]   pend_pc  [BUF_DEPTH];
  logic [PW-1:0] buf_rd, buf_wr, pend_rd, pend_wr;
  logic [CW-1:0] buf_count, outstanding, drop_cnt;
  logic          credit_ok, req_fire, rsp_keep, inst_pop;

  // Dropped responses still hold credit until they come back.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, buf_count}) < DEPTH_C;
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign rsp_keep  = imem_rsp_valid && (drop_cnt == '0);
  assign inst_pop  = inst_valid && inst_ready;

  assign imem_req_addr = pc_reg;
  assign inst_valid    = (buf_count != '0);
  assign inst_data     = buf_data[buf_rd];
  assign inst_pc       = buf_pc[buf_rd];
  assign halted        = (state == HALTED);

  always_comb begin
    state_d        = state;
    imem_req_valid = 1'b0;
    case (state)
      BOOT:   state_d = RUN;
      RUN: begin
        imem_req_valid = !redirect_valid && credit_ok;
        if (halt_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (!halt_req)                                   state_d = RUN;
        else if (outstanding == '0 && drop_cnt == '0)    state_d = HALTED;
      end
      HALTED: if (!halt_req) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state       <= BOOT;
      pc_reg      <= RESET_PC;
      buf_rd      <= '0;
      buf_wr      <= '0;
      pend_rd     <= '0;
      pend_wr     <= '0;
      buf_count   <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
        pend_pc[i]  <= '0;
      end
    end else begin
      state <= state_d;
      if (redirect_valid) begin
        // Everything in flight is stale, including a response landing this cycle.
        pc_reg      <= {redirect_pc[31:2], 2'b00};
        buf_rd      <= '0;
        buf_wr      <= '0;
        pend_rd     <= '0;
        pend_wr     <= '0;
        buf_count   <= '0;
        drop_cnt    <= outstanding - CW'(imem_rsp_valid);
        outstanding <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          pc_reg           <= pc_reg + 32'd4;
          pend_pc[pend_wr] <= pc_reg;
          pend_wr          <= pend_wr + PW'(1);
        end
        if (imem_rsp_valid) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CW'(1);
          end else begin
            buf_data[buf_wr] <= imem_rsp_data;
            buf_pc[buf_wr]   <= pend_pc[pend_rd];
            buf_wr           <= buf_wr + PW'(1);
            pend_rd          <= pend_rd + PW'(1);
          end
        end
        if (inst_pop) buf_rd <= buf_rd + PW'(1);
        outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
        buf_count   <= buf_count + CW'(rsp_keep) - CW'(inst_pop);
      end
    end
  end

`ifdef NEURAL_FETCH_PERF_EN
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (req_fire && perf_fetch_cnt != '1)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state == RUN && !inst_valid && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect_valid && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

  rsp_has_owner: assert property (@(posedge CLK) disable iff (RES)
    imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_neural_fetch_ctrl.sv
// Scoreboard bench for neural_fetch_ctrl: in-order memory model with variable latency,
// expected PC stream queue checked on every decode consume.
module tb_neural_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RES;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
`ifdef NEURAL_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  neural_fetch_ctrl #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .CLK(CLK), .RES(RES),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted)
`ifdef NEURAL_FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  int unsigned cyc = 0;
  int unsigned mem_lat = 1;
  int unsigned acc_cnt = 0;
  logic [31:0] exp_fetch = RST_PC;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(posedge CLK);
      n++;
    end
    check(tag, exp_q.size(), 0);
    #1 inst_ready = 1'b0;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 0);
    check({tag, "_req_addr"},  imem_req_addr, RST_PC);
    check({tag, "_inst_valid"}, inst_valid, 0);
    check({tag, "_inst_data"}, inst_data, 0);
    check({tag, "_inst_pc"},   inst_pc, 0);
    check({tag, "_halted"},    halted, 0);
  endtask

  // Memory: in-order responses, one per accepted request, after mem_lat cycles.
  always @(posedge CLK) begin
    cyc++;
    #1;
    if (RES) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
  end

  // Monitor: handshakes seen here complete on the following rising edge.
  always @(negedge CLK) begin
    logic [31:0] e;
    if (RES) begin
      exp_fetch = RST_PC;
    end else if (redirect_valid) begin
      check("redir_req_valid", imem_req_valid, 0);
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_fetch);
        mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
        exp_fetch = exp_fetch + 32'd4;
        acc_cnt++;
      end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          check("inst_extra", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e);
          check("inst_data", inst_data, mem_word(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int unsigned a0;
    RES = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    step(3);
    check_reset_outputs("rst");
`ifdef NEURAL_FETCH_PERF_EN
    check("perf_fetch_rst", perf_fetch_cnt, 0);
    check("perf_flush_rst", {16'h0, perf_flush_cnt}, 0);
`endif

    // Streaming fetch, latency 1
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    push_seq(32'h0, 12);
    RES = 1'b0;
    @(negedge CLK);
    check("boot_no_req", imem_req_valid, 0);
    wait_drain("p1_drain");

    // Decode stalled: credit limit reached
    step(8);
    check("stall_req_valid", imem_req_valid, 0);
    check("stall_accepts", acc_cnt, 14);
    check("stall_inst_valid", inst_valid, 1);
    check("stall_head_pc", inst_pc, 32'h30);
    push_seq(32'h30, 8);
    inst_ready = 1'b1;
    wait_drain("p2_drain");
    step(8);
    check("p2_accepts", acc_cnt, 22);

    // Redirect with two outstanding requests
    imem_req_ready = 1'b0;
    push_seq(32'h50, 2);
    inst_ready = 1'b1;
    wait_drain("p3_pre_drain");
    step(4);
    check("hold_req_valid", imem_req_valid, 1);
    check("hold_req_addr", imem_req_addr, 32'h58);
    mem_lat = 5;
    imem_req_ready = 1'b1;
    step(2);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step(1);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    push_seq(32'h100, 4);
    inst_ready = 1'b1;
    wait_drain("p3_drain");
    step(15);

    // Redirect coinciding with a response and a pop
    mem_lat = 1;
    push_seq(32'h110, 12);
    inst_ready = 1'b1;
    n = 0;
    do begin
      @(posedge CLK); #2;
      n++;
    end while (!(inst_valid && imem_rsp_valid) && n < 50);
    check("p4_align", (n < 50) ? 32'd1 : 32'd0, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(posedge CLK); #1;
    redirect_valid = 1'b0;
    exp_q.delete();
    check("flush_inst_valid", inst_valid, 0);
    push_seq(32'h200, 4);
    wait_drain("p4_drain");
    step(8);

    // Halt with two outstanding, latency 3
    imem_req_ready = 1'b0;
    push_seq(32'h210, 2);
    inst_ready = 1'b1;
    wait_drain("p5_pre_drain");
    step(4);
    mem_lat = 3;
    imem_req_ready = 1'b1;
    step(2);
    imem_req_ready = 1'b0; halt_req = 1'b1;
    a0 = acc_cnt;
    step(1);
    check("drain_no_req", imem_req_valid, 0);
    check("drain_not_halted", halted, 0);
    imem_req_ready = 1'b1;
    n = 0;
    while (!halted && n < 20) begin
      step(1);
      n++;
    end
    check("halt_reached", halted, 1);
    check("halt_no_accept", acc_cnt, a0);
    check("halt_head_pc", inst_pc, 32'h218);
    halt_req = 1'b0;
    push_seq(32'h218, 4);
    inst_ready = 1'b1;
    wait_drain("p5_drain");
    check("resume_not_halted", halted, 0);
    step(12);

    // PC wrap, redirect target low bits masked
    mem_lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    step(1);
    redirect_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    push_seq(32'h0, 2);
    inst_ready = 1'b1;
    wait_drain("p6_drain");

    // Reset mid-fetch
    push_seq(32'h8, 8);
    inst_ready = 1'b1;
    step(4);
    #2 RES = 1'b1;
    #1 check_reset_outputs("mid_rst");
    exp_q.delete();
    inst_ready = 1'b0;
    step(2);
    push_seq(RST_PC, 8);
    inst_ready = 1'b1;
    RES = 1'b0;
    wait_drain("p7_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/neural_fetch_ctrl.md
Name: neural_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the neural_darkriscv core.
- Owns the architectural fetch PC and issues in-order word requests to instruction memory.
- Buffers returned instructions with their PCs for decode.
- Handles branch/trap redirects and a halt/drain request from the debug/neural controller.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset; bits [1:0] must be 0.
- BUF_DEPTH, 2, instruction-buffer entries and in-flight credit limit; power of 2, 2..8.

Ports:
- CLK  in  1  clock
- RES  in  1  asynchronous reset, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  word-aligned fetch address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid; in order, one per accepted request, no backpressure
- imem_rsp_data  in  32  instruction word
- inst_valid  out  1  buffer head valid to decode
- inst_data  out  32  buffer head instruction
- inst_pc  out  32  buffer head PC
- inst_ready  in  1  decode consumes head
- redirect_valid  in  1  branch/trap redirect
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- halt_req  in  1  stop fetching and drain
- halted  out  1  fetch fully quiesced

Behaviour:
- Reset (RES=1, async):
  - pc_reg=RESET_PC; state=BOOT.
  - Buffer, pending-PC queue, outstanding, drop_cnt all cleared.
  - All outputs 0, except imem_req_addr=RESET_PC.
- FSM:
  - BOOT -> RUN after one cycle; no request issued in BOOT.
  - RUN -> DRAIN when halt_req=1.
  - DRAIN -> HALTED when outstanding==0 and drop_cnt==0.
  - DRAIN -> RUN if halt_req drops first.
  - HALTED -> RUN when halt_req=0.
  - halted=1 only in HALTED, registered.
- Issue:
  - imem_req_valid = (state==RUN) && !redirect_valid && (outstanding + buf_count < BUF_DEPTH).
  - imem_req_addr = pc_reg.
  - On valid&&ready: pc_reg += 4 (wraps 32'hFFFFFFFC -> 0); pc_reg pushed to pending-PC queue; outstanding++.
  - Request stays asserted with stable address until accepted. Only redirect or halt may withdraw it; memory tolerates withdrawal.
- Response:
  - On imem_rsp_valid with drop_cnt==0: pop pending-PC queue; push {data, pc} into buffer; outstanding--.
  - With drop_cnt>0: discard, drop_cnt--, outstanding--.
  - The credit rule guarantees the buffer never overflows.
  - A response while outstanding==0 is illegal; flag with an assertion.
- Output:
  - inst_valid = buf_count>0; inst_data/inst_pc are the head entry, registered storage.
  - Head is popped on inst_valid && inst_ready.
  - Zero-latency combinational from buffer state. Minimum fetch-to-inst_valid latency is 1 cycle after the response.
- Redirect (highest priority):
  - pc_reg <= {redirect_pc[31:2],2'b00}; buffer and pending-PC queue flushed.
  - drop_cnt <= outstanding, minus 1 if a response arrives the same cycle (that response is itself discarded).
  - A pop in the same cycle is ignored.
  - No request is issued in the redirect cycle; the first request to the new PC goes out the next cycle if credit allows.
  - Redirect in DRAIN/HALTED updates pc_reg; the state is unchanged.
- Simultaneous push+pop: buf_count unchanged. Push into a full buffer cannot occur.
- Reset mid-transaction clears everything; memory is reset by the same RES.

Optional Feature:
- NEURAL_FETCH_PERF_EN:
  - Defined: adds outputs perf_fetch_cnt[31:0] (accepted requests), perf_stall_cnt[31:0] (cycles with inst_valid=0 in RUN), and perf_flush_cnt[15:0] (redirects).
  - All three reset to 0; they saturate at all-ones and do not wrap.
  - Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, imem_req_ready=1, rsp 1 cycle later, inst_ready=1 -> requests 0x0,0x4,0x8... from cycle 2; inst_pc 0x0,0x4,... each with matching data.
- inst_ready=0, BUF_DEPTH=2 -> exactly 2 requests accepted, then imem_req_valid=0; release inst_ready -> issue resumes with no lost or duplicated PCs.
- Redirect to 0x103 with 2 outstanding -> next request addr 0x100; both stale responses dropped; first inst_pc=0x100.
- Redirect coinciding with rsp_valid and inst_ready pop -> response discarded, buffer empty next cycle, drop_cnt=outstanding-1.
- halt_req=1 with 2 outstanding and memory latency 3 -> halted=1 after last response; no new requests; halt_req=0 resumes at next sequential PC.
- pc_reg at 0xFFFFFFFC -> next request addr 0x00000000; RES pulsed mid-fetch -> outputs zero immediately, restart at RESET_PC.
